// File: rtl/el2_pmp_csr_regs.sv
// Machine-mode CSR front end for the PMP pmpcfg/pmpaddr registers.
// Applies WARL and lock rules, then registers one response behind valid/ready.
module el2_pmp_csr_regs #(
  parameter int PMP_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        csr_req_valid,
  output logic        csr_req_ready,
  input  logic        csr_req_write,
  input  logic [11:0] csr_req_addr,
  input  logic [31:0] csr_req_wdata,
  output logic        csr_resp_valid,
  input  logic        csr_resp_ready,
  output logic [31:0] csr_resp_rdata,
  output logic        csr_resp_err,
  output logic [7:0]  pmp_pmpcfg  [PMP_ENTRIES],
  output logic [31:0] pmp_pmpaddr [PMP_ENTRIES]
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_reg, state_next;
  logic        accept;
  logic [11:0] addr_off;
  logic [5:0]  paddr_idx;
  logic        is_cfg, is_paddr, req_err;
  logic [31:0] rd_data;
  logic [31:0] rdata_reg;
  logic        err_reg;

  assign csr_req_ready  = (state_reg == IDLE) || csr_resp_ready;
  assign accept         = csr_req_valid && csr_req_ready;
  assign csr_resp_valid = (state_reg == RESP);
  assign csr_resp_rdata = rdata_reg;
  assign csr_resp_err   = err_reg;

  // Offset wraps for addresses below 0x3B0, so one test covers 0x3B0..0x3EF.
  assign addr_off  = csr_req_addr - 12'h3B0;
  assign paddr_idx = addr_off[5:0];
  assign is_paddr  = (addr_off[11:6] == 6'd0);
  assign is_cfg    = (csr_req_addr[11:4] == 8'h3A);
  assign req_err   = !(is_cfg || is_paddr);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (is_cfg && (csr_req_addr[3:0] == 4'(i / 4)))
        rd_data[(i % 4) * 8 +: 8] = pmp_pmpcfg[i];
      if (is_paddr && (paddr_idx == 6'(i)))
        rd_data = pmp_pmpaddr[i];
    end
  end

  for (genvar gi = 0; gi < PMP_ENTRIES; gi++) begin : g_entry
    localparam int B = (gi % 4) * 8;
    logic [7:0]  cfg_reg;
    logic [31:0] addr_reg;
    logic [7:0]  cfg_new;
    logic        next_tor_lock;
    logic        cfg_we, addr_we;

    if (gi + 1 < PMP_ENTRIES) begin : g_tor
      assign next_tor_lock = pmp_pmpcfg[gi+1][7] && (pmp_pmpcfg[gi+1][4:3] == 2'b01);
    end else begin : g_last
      assign next_tor_lock = 1'b0;
    end

    // Reserved bits drop to zero; W without R is not a legal combination.
    assign cfg_new = {csr_req_wdata[B+7], 2'b00, csr_req_wdata[B+4 -: 2], csr_req_wdata[B+2],
                      csr_req_wdata[B+1] & csr_req_wdata[B], csr_req_wdata[B]};

    assign cfg_we  = accept && csr_req_write && is_cfg &&
                     (csr_req_addr[3:0] == 4'(gi / 4)) && !cfg_reg[7];
    assign addr_we = accept && csr_req_write && is_paddr &&
                     (paddr_idx == 6'(gi)) && !cfg_reg[7] && !next_tor_lock;

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        cfg_reg  <= '0;
        addr_reg <= '0;
      end else begin
        if (cfg_we)
          cfg_reg <= cfg_new;
        if (addr_we)
          addr_reg <= csr_req_wdata;
      end
    end

    assign pmp_pmpcfg[gi]  = cfg_reg;
    assign pmp_pmpaddr[gi] = addr_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (csr_resp_ready && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rdata_reg <= csr_req_write ? 32'd0 : rd_data;
        err_reg   <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_el2_pmp_csr_regs.sv
// Self-checking bench for el2_pmp_csr_regs: directed scenarios plus a
// randomized sweep checked against an array-based model of the CSR rules.
module tb_el2_pmp_csr_regs;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        csr_req_valid = 1'b0;
  logic        csr_req_ready;
  logic        csr_req_write = 1'b0;
  logic [11:0] csr_req_addr = '0;
  logic [31:0] csr_req_wdata = '0;
  logic        csr_resp_valid;
  logic        csr_resp_ready = 1'b1;
  logic [31:0] csr_resp_rdata;
  logic        csr_resp_err;
  logic [7:0]  cfg_o  [N];
  logic [31:0] addr_o [N];

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_cfg  [N];
  logic [31:0] m_addr [N];

  always #5 clk = ~clk;

  el2_pmp_csr_regs #(.PMP_ENTRIES(N)) dut (
    .clk(clk), .rst_l(rst_l),
    .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
    .csr_req_write(csr_req_write), .csr_req_addr(csr_req_addr),
    .csr_req_wdata(csr_req_wdata),
    .csr_resp_valid(csr_resp_valid), .csr_resp_ready(csr_resp_ready),
    .csr_resp_rdata(csr_resp_rdata), .csr_resp_err(csr_resp_err),
    .pmp_pmpcfg(cfg_o), .pmp_pmpaddr(addr_o)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = 32'h0;
    end
  endfunction

  function automatic bit m_locked(input int e);
    return m_cfg[e] >= 8'h80;
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] d);
    int k, e, i;
    logic [7:0] b;
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      k = int'(a) - 'h3A0;
      for (int j = 0; j < 4; j++) begin
        e = 4 * k + j;
        if (e < N && !m_locked(e)) begin
          b = 8'((d >> (8 * j)) & 32'hFF) & 8'h9F;
          if ((b & 8'h03) == 8'h02) b = b - 8'h02;
          m_cfg[e] = b;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      i = int'(a) - 'h3B0;
      if (i < N && !m_locked(i)) begin
        if (!(i + 1 < N && m_locked(i + 1) && ((m_cfg[i+1] >> 3) & 8'h3) == 8'h1))
          m_addr[i] = d;
      end
    end
  endfunction

  function automatic void m_read(input logic [11:0] a, output logic [31:0] d, output logic er);
    int k, i;
    d = 32'h0;
    er = 1'b0;
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      k = int'(a) - 'h3A0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < N) d = d | (32'(m_cfg[4*k+j]) << (8 * j));
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      i = int'(a) - 'h3B0;
      if (i < N) d = m_addr[i];
    end else begin
      er = 1'b1;
    end
  endfunction

  function automatic int out_mismatches();
    int n = 0;
    for (int i = 0; i < N; i++)
      if (cfg_o[i] !== m_cfg[i] || addr_o[i] !== m_addr[i]) n++;
    return n;
  endfunction

  // One accepted request; returns response sampled 1ns after the accept edge.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output logic rv_before, output logic rv_after);
    int n;
    rd = 'x; er = 'x; rv_before = 'x; rv_after = 'x;
    @(negedge clk);
    csr_req_valid = 1'b1; csr_req_write = wr; csr_req_addr = a; csr_req_wdata = d;
    n = 0;
    while (!csr_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!csr_req_ready) begin
      checks++; failures++;
      $display("FAIL xfer_timeout addr=%h req_ready stayed 0, required 1", a);
      csr_req_valid = 1'b0;
      return;
    end
    rv_before = csr_resp_valid;
    @(posedge clk);
    if (wr) m_write(a, d);
    #1;
    csr_req_valid = 1'b0;
    rv_after = csr_resp_valid;
    rd = csr_resp_rdata;
    er = csr_resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, rb, ra;
    rst_l = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    checks++;
    if (csr_resp_valid !== 1'b0 || csr_req_ready !== 1'b1 || csr_resp_rdata !== 32'h0 || csr_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake valid=%b ready=%b rdata=%h err=%b required 0/1/0/0",
               csr_resp_valid, csr_req_ready, csr_resp_rdata, csr_resp_err);
    end
    checks++;
    if (out_mismatches() !== 0) begin
      failures++;
      $display("FAIL reset_outputs mismatched_entries=%0d required 0", out_mismatches());
    end
    xfer(1'b0, 12'h3A0, 32'h0, rd, er, rb, ra);
    checks++;
    if (rb !== 1'b0 || ra !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL reset_read_3A0 vbefore=%b vafter=%b rdata=%h err=%b required 0/1/00000000/0", rb, ra, rd, er);
    end
    xfer(1'b0, 12'h3B5, 32'h0, rd, er, rb, ra);
    checks++;
    if (rb !== 1'b0 || ra !== 1'b1 || rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL reset_read_3B5 vbefore=%b vafter=%b rdata=%h err=%b required 0/1/00000000/0", rb, ra, rd, er);
    end
  endtask

  task automatic test_cfg_warl();
    logic [31:0] rd; logic er, rb, ra;
    xfer(1'b1, 12'h3A0, 32'h8F0D0A03, rd, er, rb, ra);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL warl_write_resp rdata=%h err=%b required 00000000/0", rd, er);
    end
    checks++;
    if (cfg_o[0] !== 8'h03 || cfg_o[1] !== 8'h08 || cfg_o[2] !== 8'h0D || cfg_o[3] !== 8'h8F) begin
      failures++;
      $display("FAIL warl_entries got %h %h %h %h required 03 08 0d 8f", cfg_o[0], cfg_o[1], cfg_o[2], cfg_o[3]);
    end
    xfer(1'b0, 12'h3A0, 32'h0, rd, er, rb, ra);
    checks++;
    if (rd !== 32'h8F0D0803 || er !== 1'b0) begin
      failures++;
      $display("FAIL warl_readback rdata=%h err=%b required 8f0d0803/0", rd, er);
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd; logic er, rb, ra;
    xfer(1'b1, 12'h3A0, 32'h0, rd, er, rb, ra);
    xfer(1'b0, 12'h3A0, 32'h0, rd, er, rb, ra);
    checks++;
    if (rd !== 32'h8F000000) begin
      failures++;
      $display("FAIL lock_cfg_sticky rdata=%h required 8f000000", rd);
    end
    xfer(1'b1, 12'h3B3, 32'h1234, rd, er, rb, ra);
    xfer(1'b1, 12'h3B2, 32'h5678, rd, er, rb, ra);
    checks++;
    if (addr_o[3] !== 32'h0 || addr_o[2] !== 32'h0) begin
      failures++;
      $display("FAIL lock_pmpaddr addr3=%h addr2=%h required 0/0", addr_o[3], addr_o[2]);
    end
    xfer(1'b1, 12'h3B1, 32'hAAAA, rd, er, rb, ra);
    checks++;
    if (addr_o[1] !== 32'hAAAA) begin
      failures++;
      $display("FAIL unlocked_pmpaddr1 got=%h required 0000aaaa", addr_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] seq [4];
    logic [31:0] ed; logic ee;
    seq[0] = 12'h3B0; seq[1] = 12'h3A0; seq[2] = 12'h3B1; seq[3] = 12'h3A0;
    @(negedge clk);
    csr_resp_ready = 1'b0;
    csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = 12'h3B0; csr_req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    m_write(12'h3B0, 32'hDEADBEEF);
    #1;
    csr_req_write = 1'b0; csr_req_addr = seq[0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (csr_req_ready !== 1'b0 || csr_resp_valid !== 1'b1 || csr_resp_rdata !== 32'h0 || csr_resp_err !== 1'b0) begin
        failures++;
        $display("FAIL stall_cycle%0d ready=%b valid=%b rdata=%h err=%b required 0/1/00000000/0",
                 c, csr_req_ready, csr_resp_valid, csr_resp_rdata, csr_resp_err);
      end
      checks++;
      if (addr_o[0] !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL stall_pmpaddr0 got=%h required deadbeef", addr_o[0]);
      end
    end
    @(negedge clk);
    csr_resp_ready = 1'b1;
    #1;
    checks++;
    if (csr_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got=%b required 1", csr_req_ready);
    end
    for (int b = 0; b < 4; b++) begin
      m_read(seq[b], ed, ee);
      @(posedge clk);
      #1;
      checks++;
      if (csr_resp_valid !== 1'b1 || csr_resp_rdata !== ed || csr_resp_err !== ee) begin
        failures++;
        $display("FAIL b2b_%0d valid=%b rdata=%h err=%b required 1/%h/%b",
                 b, csr_resp_valid, csr_resp_rdata, csr_resp_err, ed, ee);
      end
      if (b < 3) csr_req_addr = seq[b+1];
      else csr_req_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (csr_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain valid=%b required 0", csr_resp_valid);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic er, rb, ra;
    logic [11:0] al [3];
    logic        el [3];
    al[0] = 12'h300; el[0] = 1'b1;
    al[1] = 12'h3A4; el[1] = 1'b0;
    al[2] = 12'h3C0; el[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      xfer(1'b1, al[t], 32'hFFFFFFFF, rd, er, rb, ra);
      checks++;
      if (rd !== 32'h0 || er !== el[t]) begin
        failures++;
        $display("FAIL unmapped_wr_%h rdata=%h err=%b required 00000000/%b", al[t], rd, er, el[t]);
      end
      xfer(1'b0, al[t], 32'h0, rd, er, rb, ra);
      checks++;
      if (rd !== 32'h0 || er !== el[t]) begin
        failures++;
        $display("FAIL unmapped_rd_%h rdata=%h err=%b required 00000000/%b", al[t], rd, er, el[t]);
      end
    end
    checks++;
    if (out_mismatches() !== 0) begin
      failures++;
      $display("FAIL unmapped_state mismatched_entries=%0d required 0", out_mismatches());
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic er, rb, ra;
    @(negedge clk);
    csr_resp_ready = 1'b0;
    csr_req_valid = 1'b1; csr_req_write = 1'b0; csr_req_addr = 12'h3A0;
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    checks++;
    if (csr_resp_valid !== 1'b1 || cfg_o[3] !== 8'h8F) begin
      failures++;
      $display("FAIL midrst_setup valid=%b cfg3=%h required 1/8f", csr_resp_valid, cfg_o[3]);
    end
    #3;
    rst_l = 1'b0;
    #1;
    checks++;
    if (csr_resp_valid !== 1'b0 || cfg_o[3] !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async valid=%b cfg3=%h required 0/00", csr_resp_valid, cfg_o[3]);
    end
    m_reset();
    csr_resp_ready = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;
    xfer(1'b1, 12'h3A0, 32'h03000000, rd, er, rb, ra);
    xfer(1'b0, 12'h3A0, 32'h0, rd, er, rb, ra);
    checks++;
    if (rd !== 32'h03000000 || cfg_o[3] !== 8'h03) begin
      failures++;
      $display("FAIL midrst_unlocked rdata=%h cfg3=%h required 03000000/03", rd, cfg_o[3]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ed, d; logic er, ee, rb, ra;
    logic [11:0] a;
    bit wr;
    int sel;
    for (int t = 0; t < 300; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3)      a = 12'h3A0 + 12'($urandom_range(0, 3));
      else if (sel <= 6) a = 12'h3B0 + 12'($urandom_range(0, 15));
      else if (sel == 7) a = 12'h3A4 + 12'($urandom_range(0, 11));
      else if (sel == 8) a = 12'h3C0 + 12'($urandom_range(0, 47));
      else               a = 12'($urandom);
      d = $urandom;
      if ($urandom_range(0, 15) != 0) d = d & 32'h7F7F7F7F;
      wr = $urandom_range(0, 1) == 1;
      m_read(a, ed, ee);
      if (wr) ed = 32'h0;
      xfer(wr, a, d, rd, er, rb, ra);
      checks++;
      if (ra !== 1'b1 || rd !== ed || er !== ee) begin
        failures++;
        $display("FAIL rand_%0d wr=%0d addr=%h valid=%b rdata=%h err=%b required 1/%h/%b",
                 t, wr, a, ra, rd, er, ed, ee);
      end
      checks++;
      if (out_mismatches() !== 0) begin
        failures++;
        $display("FAIL rand_state_%0d addr=%h mismatched_entries=%0d required 0", t, a, out_mismatches());
      end
    end
  endtask

  initial begin
    test_reset();
    test_cfg_warl();
    test_lock();
    test_back_to_back();
    test_unmapped();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
